// File: rtl/compressor_channel_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// compressor_channel_scheduler_pkg
// Shared definitions for the compressor channel scheduler:
//   - sched_state_t : sweep sequencer state encoding (IDLE..PUBLISH)
//   - DEFAULT_DB_W  : default width of signed dB values
//   - field_lsb()   : LSB position of channel k inside a packed per-channel bus
// ---------------------------------------------------------------------------
package compressor_channel_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_UPDATE  = 3'd3,
        ST_PUBLISH = 3'd4
    } sched_state_t;

    localparam int DEFAULT_DB_W = 9;

    // Channel k of a packed bus occupies bits [field_lsb(k, w) +: w].
    function automatic int field_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/compressor_channel_scheduler_gain_slew_limiter.sv
// ---------------------------------------------------------------------------
// gain_slew_limiter
// Combinational per-sweep slew clamp used when gain smoothing is built in
// (COMP_SCHED_SMOOTHING_EN). A falling gain may drop by at most ATTACK_STEP
// dB, a rising gain may climb by at most RELEASE_STEP dB, equal gains pass.
// Ports:
//   old_gain     in  DB_W  signed gain currently published for the channel
//   new_gain     in  DB_W  signed gain just returned by the gain computer
//   limited_gain out DB_W  signed gain to store
// ---------------------------------------------------------------------------
module gain_slew_limiter #(
    parameter int DB_W         = 9,
    parameter int ATTACK_STEP  = 4,
    parameter int RELEASE_STEP = 1
) (
    input  logic [DB_W-1:0] old_gain,
    input  logic [DB_W-1:0] new_gain,
    output logic [DB_W-1:0] limited_gain
);

    localparam logic signed [DB_W:0] ATTACK_EXT  = (DB_W+1)'(ATTACK_STEP);
    localparam logic signed [DB_W:0] RELEASE_EXT = (DB_W+1)'(RELEASE_STEP);

    // One extra bit so old-ATTACK and old+RELEASE cannot wrap.
    logic signed [DB_W:0] old_ext;
    logic signed [DB_W:0] new_ext;
    logic signed [DB_W:0] floor_v;
    logic signed [DB_W:0] ceil_v;
    logic signed [DB_W:0] limited_ext;

    always_comb begin
        old_ext = {old_gain[DB_W-1], old_gain};
        new_ext = {new_gain[DB_W-1], new_gain};
        floor_v = old_ext - ATTACK_EXT;
        ceil_v  = old_ext + RELEASE_EXT;
        limited_ext = new_ext;
        if (new_ext < floor_v) begin
            limited_ext = floor_v;
        end else if (new_ext > ceil_v) begin
            limited_ext = ceil_v;
        end
    end

    // The result always lies between old and new, both in DB_W range,
    // so dropping the guard bit cannot change the value.
    assign limited_gain = DB_W'(limited_ext);

endmodule

// File: rtl/compressor_channel_scheduler.sv
// ---------------------------------------------------------------------------
// compressor_channel_scheduler
// Time-shares one compression gain computer across N_CHANNELS channels.
// A sample strobe snapshots every channel level; the sequencer then walks the
// channels round-robin through the gain computer's start/done handshake,
// stores one gain per channel and publishes the vector with gains_valid.
// Optional build macro: COMP_SCHED_SMOOTHING_EN (slew-limited gain update).
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   sample_strobe           one-cycle pulse per audio sample period
//   level_db                packed signed levels, channel k at [k*DB_W +: DB_W]
//   compression_amount      ratio select, registered at snapshot
//   gc_start                start pulse to the gain computer (ISSUE only)
//   gc_input_db             snapshot level of the channel being served
//   gc_compression_amount   registered compression_amount
//   gc_output_gain, gc_done result and done level from the gain computer
//   gain_db                 packed per-channel gains, same packing as level_db
//   gains_valid             one-cycle pulse once gain_db is fully updated
//   busy                    high from snapshot until the sweep ends
//   overrun                 sticky: strobe arrived while busy
//   timeout_err             sticky: a channel got no answer in time
// ---------------------------------------------------------------------------
module compressor_channel_scheduler
    import compressor_channel_scheduler_pkg::*;
#(
    parameter int N_CHANNELS     = 4,
    parameter int DB_W           = DEFAULT_DB_W,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ATTACK_STEP    = 4,
    parameter int RELEASE_STEP   = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       sample_strobe,
    input  logic [N_CHANNELS*DB_W-1:0] level_db,
    input  logic [1:0]                 compression_amount,
    output logic                       gc_start,
    output logic [DB_W-1:0]            gc_input_db,
    output logic [1:0]                 gc_compression_amount,
    input  logic [DB_W-1:0]            gc_output_gain,
    input  logic                       gc_done,
    output logic [N_CHANNELS*DB_W-1:0] gain_db,
    output logic                       gains_valid,
    output logic                       busy,
    output logic                       overrun,
    output logic                       timeout_err
);

    localparam int CH_W   = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(N_CHANNELS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    sched_state_t state;
    sched_state_t state_next;

    logic [CH_W-1:0]   ch;
    logic [WAIT_W-1:0] wait_count;
    logic [DB_W-1:0]   level_field [N_CHANNELS];
    logic [DB_W-1:0]   snapshot    [N_CHANNELS];
    logic [DB_W-1:0]   gain_mem    [N_CHANNELS];
    logic [DB_W-1:0]   captured_gain;
    logic              capture_valid;
    logic [DB_W-1:0]   write_gain;
    logic              done_ok;
    logic              timeout_hit;

    for (genvar k = 0; k < N_CHANNELS; k++) begin : g_pack
        assign level_field[k]                      = level_db[field_lsb(k, DB_W) +: DB_W];
        assign gain_db[field_lsb(k, DB_W) +: DB_W] = gain_mem[k];
    end

    // wait_count is 0 on the first WAIT cycle; done seen there may be the
    // previous operation's level that the gain computer has not cleared yet.
    assign done_ok     = (state == ST_WAIT) && gc_done && (wait_count != '0);
    assign timeout_hit = (state == ST_WAIT) && !done_ok && (wait_count == WAIT_LAST);

    assign busy        = (state != ST_IDLE);
    assign gc_input_db = snapshot[ch];

`ifdef COMP_SCHED_SMOOTHING_EN
    gain_slew_limiter #(
        .DB_W         (DB_W),
        .ATTACK_STEP  (ATTACK_STEP),
        .RELEASE_STEP (RELEASE_STEP)
    ) u_slew (
        .old_gain     (gain_mem[ch]),
        .new_gain     (captured_gain),
        .limited_gain (write_gain)
    );
`else
    assign write_gain = captured_gain;

    logic unused_steps;
    assign unused_steps = ^{32'(ATTACK_STEP), 32'(RELEASE_STEP)};
`endif

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        gc_start    = 1'b0;
        gains_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sample_strobe) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                gc_start   = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_ok || timeout_hit) begin
                    state_next = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                state_next = (ch == LAST_CH) ? ST_PUBLISH : ST_ISSUE;
            end
            ST_PUBLISH: begin
                gains_valid = 1'b1;
                state_next  = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // NOTE: snapshot and gain arrays are small register banks with a defined
    // reset value (gain_db must read 0 after reset), not RAMs, so they are
    // cleared explicitly.
    always_ff @(posedge clock) begin
        if (reset) begin
            ch                    <= '0;
            wait_count            <= '0;
            captured_gain         <= '0;
            capture_valid         <= 1'b0;
            gc_compression_amount <= '0;
            overrun               <= 1'b0;
            timeout_err           <= 1'b0;
            for (int k = 0; k < N_CHANNELS; k++) begin
                snapshot[k] <= '0;
                gain_mem[k] <= '0;
            end
        end else begin
            // A strobe during a sweep (PUBLISH included) is dropped.
            if (sample_strobe && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (sample_strobe) begin
                        for (int k = 0; k < N_CHANNELS; k++) begin
                            snapshot[k] <= level_field[k];
                        end
                        gc_compression_amount <= compression_amount;
                        ch                    <= '0;
                    end
                end
                ST_ISSUE: begin
                    wait_count <= '0;
                end
                ST_WAIT: begin
                    wait_count <= wait_count + 1'b1;
                    if (done_ok) begin
                        captured_gain <= gc_output_gain;
                        capture_valid <= 1'b1;
                    end else if (timeout_hit) begin
                        capture_valid <= 1'b0;
                        timeout_err   <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    if (capture_valid) begin
                        gain_mem[ch] <= write_gain;
                    end
                    if (ch != LAST_CH) begin
                        ch <= ch + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_compressor_channel_scheduler.sv
// ---------------------------------------------------------------------------
// tb_compressor_channel_scheduler
// Directed bench for compressor_channel_scheduler (N=4, DB_W=9, timeout 16).
// A behavioural gain computer answers input-10: done clears one cycle after
// start is seen and rises again the cycle after, with a stale-done injection
// and a per-level "never answer" hook. Expected gains are tracked per channel
// (with slew limiting when COMP_SCHED_SMOOTHING_EN is defined).
// ---------------------------------------------------------------------------
module tb_compressor_channel_scheduler;

    localparam int N  = 4;
    localparam int W  = 9;
    localparam int TO = 16;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           sample_strobe = 1'b0;
    logic [N*W-1:0] level_db = '0;
    logic [1:0]     compression_amount = 2'd0;
    logic           gc_start;
    logic [W-1:0]   gc_input_db;
    logic [1:0]     gc_compression_amount;
    logic [W-1:0]   gc_output_gain;
    logic           gc_done;
    logic [N*W-1:0] gain_db;
    logic           gains_valid;
    logic           busy;
    logic           overrun;
    logic           timeout_err;

    int errors = 0;
    int checks = 0;

    compressor_channel_scheduler #(
        .N_CHANNELS     (N),
        .DB_W           (W),
        .TIMEOUT_CYCLES (TO),
        .ATTACK_STEP    (4),
        .RELEASE_STEP   (1)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .sample_strobe         (sample_strobe),
        .level_db              (level_db),
        .compression_amount    (compression_amount),
        .gc_start              (gc_start),
        .gc_input_db           (gc_input_db),
        .gc_compression_amount (gc_compression_amount),
        .gc_output_gain        (gc_output_gain),
        .gc_done               (gc_done),
        .gain_db               (gain_db),
        .gains_valid           (gains_valid),
        .busy                  (busy),
        .overrun               (overrun),
        .timeout_err           (timeout_err)
    );

    always #5 clock = ~clock;

    // ---------------- gain computer model ----------------
    logic [1:0]   gc_stage;
    logic [W-1:0] gc_pending;
    logic         gc_drop_pending;
    logic         stale_req = 1'b0;
    logic         drop_en = 1'b0;
    logic [W-1:0] drop_level = '0;
    int           start_count = 0;
    logic [W-1:0] start_log [$];
    int           valid_count = 0;

    always @(posedge clock) begin
        if (reset) begin
            gc_stage       <= 2'd0;
            gc_done        <= 1'b0;
            gc_output_gain <= '0;
        end else if (stale_req) begin
            gc_done        <= 1'b1;
            gc_output_gain <= 9'sd99;
        end else if (gc_start) begin
            gc_stage        <= 2'd1;
            gc_pending      <= W'(int'($signed(gc_input_db)) - 10);
            gc_drop_pending <= drop_en && (gc_input_db == drop_level);
            start_count     <= start_count + 1;
            start_log.push_back(gc_input_db);
        end else if (gc_stage == 2'd1) begin
            gc_done  <= 1'b0;
            gc_stage <= 2'd2;
        end else if (gc_stage == 2'd2) begin
            gc_stage <= 2'd0;
            if (!gc_drop_pending) begin
                gc_done        <= 1'b1;
                gc_output_gain <= gc_pending;
            end
        end
    end

    always @(posedge clock) begin
        if (!reset && gains_valid === 1'b1) begin
            valid_count <= valid_count + 1;
        end
    end

    // ---------------- expectation helpers ----------------
    int cur_level [N];
    int exp_gain  [N];

    function automatic int smooth(input int old_v, input int new_v);
`ifdef COMP_SCHED_SMOOTHING_EN
        if (new_v < old_v) return (new_v > old_v - 4) ? new_v : old_v - 4;
        if (new_v > old_v) return (new_v < old_v + 1) ? new_v : old_v + 1;
        return old_v;
`else
        return new_v + 0 * old_v;
`endif
    endfunction

    function automatic logic signed [31:0] gain_of(input int k);
        return $signed(gain_db[k*W +: W]);
    endfunction

    task automatic check(input string tag, input logic signed [31:0] observed,
                         input logic signed [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic set_levels(input int l0, input int l1, input int l2, input int l3);
        cur_level[0] = l0;
        cur_level[1] = l1;
        cur_level[2] = l2;
        cur_level[3] = l3;
        level_db = {W'(l3), W'(l2), W'(l1), W'(l0)};
    endtask

    task automatic do_strobe();
        @(negedge clock);
        sample_strobe = 1'b1;
        @(negedge clock);
        sample_strobe = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < N; k++) check($sformatf("%s_gain%0d", tag, k), gain_of(k), 0);
        check({tag, "_gc_start"}, gc_start, 0);
        check({tag, "_gc_input"}, gc_input_db, 0);
        check({tag, "_valid"}, gains_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_timeout"}, timeout_err, 0);
        check({tag, "_amount"}, gc_compression_amount, 0);
    endtask

    // One full sweep: strobe, optional dropped second strobe, bounded wait
    // for gains_valid, then gains, request order and the end-of-sweep edge.
    task automatic run_sweep(input string tag, input bit second_strobe);
        int  base_starts;
        int  base_valid;
        bit  got;
        base_starts = start_count;
        base_valid  = valid_count;
        for (int k = 0; k < N; k++) begin
            if (!(drop_en && W'(cur_level[k]) == drop_level))
                exp_gain[k] = smooth(exp_gain[k], cur_level[k] - 10);
        end
        do_strobe();
        if (second_strobe) begin
            repeat (4) @(negedge clock);
            sample_strobe      = 1'b1;
            compression_amount = 2'd1;
            @(negedge clock);
            sample_strobe = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clock);
            if (gains_valid === 1'b1) got = 1'b1;
        end
        if (!got) begin
            check({tag, "_valid_seen"}, 0, 1);
        end else begin
            for (int k = 0; k < N; k++)
                check($sformatf("%s_gain%0d", tag, k), gain_of(k), exp_gain[k]);
            check({tag, "_starts"}, start_count - base_starts, N);
            if (start_count - base_starts == N) begin
                for (int k = 0; k < N; k++)
                    check($sformatf("%s_order%0d", tag, k),
                          $signed(start_log[base_starts + k]), cur_level[k]);
            end
            @(negedge clock);
            check({tag, "_busy_after"}, busy, 0);
            check({tag, "_valid_after"}, gains_valid, 0);
            check({tag, "_valid_count"}, valid_count - base_valid, 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int base_starts;
        int base_valid;

        for (int k = 0; k < N; k++) begin
            exp_gain[k]  = 0;
            cur_level[k] = 0;
        end

        // Reset state
        repeat (2) @(negedge clock);
        check_reset_outputs("rst");
        reset = 1'b0;

        // Basic sweep
        set_levels(-5, -30, -60, 0);
        compression_amount = 2'd2;
        run_sweep("basic", 1'b0);
        check("basic_amount", gc_compression_amount, 2);
        check("basic_no_timeout", timeout_err, 0);
        check("basic_no_overrun", overrun, 0);
        base_starts = start_count;
        repeat (10) @(negedge clock);
        check("idle_no_start", start_count - base_starts, 0);

        // Stale done: done held high with a bogus result before the strobe
        @(negedge clock);
        stale_req = 1'b1;
        @(negedge clock);
        stale_req = 1'b0;
        check("stale_done_high", gc_done, 1);
        set_levels(20, -100, 5, -7);
        run_sweep("stale", 1'b0);

        // Timeout: channel 2 (level -60) is never answered
        drop_en    = 1'b1;
        drop_level = W'(-60);
        set_levels(1, 2, -60, 3);
        run_sweep("tmo", 1'b0);
        check("tmo_err", timeout_err, 1);
        drop_en = 1'b0;

        // Overrun: second strobe mid-sweep is dropped
        compression_amount = 2'd3;
        set_levels(0, 0, 0, 0);
        run_sweep("ovr", 1'b1);
        check("ovr_flag", overrun, 1);
        check("ovr_amount_kept", gc_compression_amount, 3);
        base_starts = start_count;
        base_valid  = valid_count;
        repeat (40) @(negedge clock);
        check("ovr_no_second_sweep", start_count - base_starts, 0);
        check("ovr_no_second_valid", valid_count - base_valid, 0);
        check("ovr_idle", busy, 0);

        // Reset in the middle of WAIT
        set_levels(50, 40, 30, 20);
        base_starts = start_count;
        base_valid  = valid_count;
        do_strobe();
        @(negedge clock);
        check("mid_busy", busy, 1);
        reset = 1'b1;
        @(negedge clock);
        check_reset_outputs("midrst");
        reset = 1'b0;
        for (int k = 0; k < N; k++) exp_gain[k] = 0;
        repeat (30) @(negedge clock);
        check("midrst_no_valid", valid_count - base_valid, 0);
        check("midrst_one_start", start_count - base_starts, 1);
        set_levels(-5, -30, -60, 0);
        run_sweep("fresh", 1'b0);
        check("fresh_no_timeout", timeout_err, 0);
        check("fresh_no_overrun", overrun, 0);

`ifdef COMP_SCHED_SMOOTHING_EN
        begin
            int sm_exp [7];
            sm_exp = '{-4, -8, -12, -16, -20, -19, -18};
            @(negedge clock);
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
            for (int k = 0; k < N; k++) exp_gain[k] = 0;
            for (int s = 0; s < 7; s++) begin
                if (s < 5) set_levels(-10, -10, -10, -10);
                else       set_levels(10, 10, 10, 10);
                run_sweep($sformatf("smooth%0d", s), 1'b0);
                check($sformatf("smooth%0d_ch0_hand", s), gain_of(0), sm_exp[s]);
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
